// File: rtl/multicycle_control_if.sv
// multicycle_control_if: datapath <-> control bus for the multicycle MIPS core
interface multicycle_control_if;
   logic [5:0] Op;
   logic [5:0] Function;
   logic       Zero;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       PCSource;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic       RegDst;
   logic       PCSel;
   logic [3:0] ALUCtrl;
   logic [3:0] state;
   logic       illegal;
   modport master (
      input  Op, Function, Zero,
      output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, ALUSrcB,
             RegWrite, RegDst, PCSel, ALUCtrl, state, illegal
   );
   modport slave (
      output Op, Function, Zero,
      input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, ALUSrcB,
             RegWrite, RegDst, PCSel, ALUCtrl, state, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core
module multicycle_control (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0111;
   localparam logic [3:0] A_NOR = 4'b1100;
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      RTEX = 4'd6, RTWB = 4'd7, BRANCH = 4'd8, IMMEX = 4'd9, IMMWB = 4'd10
   } st_t;
   typedef struct packed {
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       irwrite;
      logic       pcsource;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       regwrite;
      logic       regdst;
      logic       pcw;
      logic       br;
      logic [3:0] aluctrl;
   } ctl_t;
   st_t  st, nxt;
   ctl_t c;
   logic bad;
   function automatic logic [3:0] rfun(logic [5:0] fn);
      return fn == 6'b100010 ? A_SUB :
             fn == 6'b100100 ? A_AND :
             fn == 6'b100101 ? A_OR  :
             fn == 6'b101010 ? A_SLT :
             fn == 6'b100111 ? A_NOR : A_ADD;
   endfunction
   function automatic logic rlegal(logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   endfunction
   // Control word for the state about to be entered, so outputs come straight from flops
   function automatic ctl_t dec(st_t s, logic [5:0] op, logic [5:0] fn);
      ctl_t k;
      k = '0;
      k.aluctrl = A_ADD;
      case (s)
         FETCH:  begin k.memread = 1'b1; k.irwrite = 1'b1; k.alusrcb = 2'b01; k.pcw = 1'b1; end
         DECODE: k.alusrcb = 2'b10;
         MEMADR: begin k.alusrca = 1'b1; k.alusrcb = 2'b10; end
         MEMRD:  begin k.memread = 1'b1; k.iord = 1'b1; end
         MEMWB:  begin k.regwrite = 1'b1; k.memtoreg = 1'b1; end
         MEMWR:  begin k.memwrite = 1'b1; k.iord = 1'b1; end
         RTEX:   begin k.alusrca = 1'b1; k.aluctrl = rfun(fn); end
         RTWB:   begin k.regwrite = 1'b1; k.regdst = 1'b1; end
         BRANCH: begin k.alusrca = 1'b1; k.aluctrl = A_SUB; k.pcsource = 1'b1; k.br = 1'b1; end
         IMMEX:  begin k.alusrca = 1'b1; k.alusrcb = 2'b10; k.aluctrl = op == OP_SLTI ? A_SLT : A_ADD; end
         IMMWB:  k.regwrite = 1'b1;
         default: ;
      endcase
      return k;
   endfunction
   always_comb begin
      bad = 1'b0;
      nxt = FETCH;
      case (st)
         FETCH:  nxt = DECODE;
         DECODE: begin
            nxt = bus.Op inside {OP_LW, OP_SW} ? MEMADR :
                  bus.Op == OP_RTYPE && rlegal(bus.Function) ? RTEX :
                  bus.Op == OP_BEQ ? BRANCH :
                  bus.Op inside {OP_ADDI, OP_SLTI} ? IMMEX : FETCH;
            bad = nxt == FETCH;
         end
         MEMADR: nxt = bus.Op == OP_LW ? MEMRD : bus.Op == OP_SW ? MEMWR : FETCH;
         MEMRD:  nxt = MEMWB;
         RTEX:   nxt = RTWB;
         IMMEX:  nxt = IMMWB;
         default: nxt = FETCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= FETCH;
         c       <= dec(FETCH, bus.Op, bus.Function);
         bus.illegal <= 1'b0;
      end else begin
         st <= nxt;
         c  <= dec(nxt, bus.Op, bus.Function);
         if (bad) bus.illegal <= 1'b1;
      end
   end
   assign bus.IorD     = c.iord;
   assign bus.MemRead  = c.memread;
   assign bus.MemWrite = c.memwrite & ~reset;
   assign bus.MemtoReg = c.memtoreg;
   assign bus.IRWrite  = c.irwrite & ~reset;
   assign bus.PCSource = c.pcsource;
   assign bus.ALUSrcA  = c.alusrca;
   assign bus.ALUSrcB  = c.alusrcb;
   assign bus.RegWrite = c.regwrite & ~reset;
   assign bus.RegDst   = c.regdst;
   // BRANCH is the only state whose PC write follows the live Zero flag
   assign bus.PCSel    = (c.pcw | (c.br & bus.Zero)) & ~reset;
   assign bus.ALUCtrl  = c.aluctrl;
   assign bus.state    = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table, hand-written and random checks of the control FSM
module tb_multicycle_control;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      int          len;
      logic [19:0] seq;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic exp_ill;
   int   exp_q[$];
   vec_t tab[16];
   logic [5:0] legal_fn[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   multicycle_control_if bus ();
   multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [15:0] ctl_model(int s, logic [5:0] op, logic [5:0] fn, logic z, logic r);
      logic iord, mr, mw, m2r, irw, pcs, sa, rw, rd, pw;
      logic [1:0] sb;
      logic [3:0] alu;
      {iord, mr, mw, m2r, irw, pcs, sa, rw, rd, pw} = '0;
      sb = 2'b00;
      alu = 4'b0010;
      case (s)
         0: begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
         1: sb = 2'b10;
         2: begin sa = 1; sb = 2'b10; end
         3: begin mr = 1; iord = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mw = 1; iord = 1; end
         6: begin
            sa = 1;
            case (fn)
               6'b100010: alu = 4'b0110;
               6'b100100: alu = 4'b0000;
               6'b100101: alu = 4'b0001;
               6'b101010: alu = 4'b0111;
               6'b100111: alu = 4'b1100;
               default:   alu = 4'b0010;
            endcase
         end
         7: begin rw = 1; rd = 1; end
         8: begin sa = 1; alu = 4'b0110; pcs = 1; pw = z; end
         9: begin sa = 1; sb = 2'b10; alu = (op == OP_SLTI) ? 4'b0111 : 4'b0010; end
         10: rw = 1;
         default: ;
      endcase
      if (r) {mw, rw, irw, pw} = '0;
      return {iord, mr, mw, m2r, irw, pcs, sa, sb, rw, rd, pw, alu};
   endfunction
   // Expected state trace from the instruction class alone
   function automatic void build_seq(logic [5:0] op, logic [5:0] fn);
      logic rok;
      rok = 1'b0;
      foreach (legal_fn[i]) if (legal_fn[i] == fn) rok = 1'b1;
      if (op == OP_LW) exp_q = '{0, 1, 2, 3, 4};
      else if (op == OP_SW) exp_q = '{0, 1, 2, 5};
      else if (op == OP_RTYPE && rok) exp_q = '{0, 1, 6, 7};
      else if (op == OP_BEQ) exp_q = '{0, 1, 8};
      else if (op == OP_ADDI || op == OP_SLTI) exp_q = '{0, 1, 9, 10};
      else exp_q = '{0, 1};
   endfunction
   task automatic step_check(input int es, input string tag);
      logic [15:0] act, exp;
      #1;
      act = {bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.PCSource,
             bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.RegDst, bus.PCSel, bus.ALUCtrl};
      exp = ctl_model(es, bus.Op, bus.Function, bus.Zero, reset);
      vectors++;
      if (bus.state !== es[3:0] || act !== exp || bus.illegal !== exp_ill) begin
         miscompares++;
         $display("FAIL %s op=%b fn=%b: state=%0d want %0d ctl=%h want %h illegal=%b want %b",
                  tag, bus.Op, bus.Function, bus.state, es, act, exp, bus.illegal, exp_ill);
      end
      if (reset) exp_ill = 1'b0;
      @(negedge clk);
   endtask
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag);
      bus.Op = op;
      bus.Function = fn;
      bus.Zero = z;
      foreach (exp_q[i]) step_check(exp_q[i], tag);
      if (exp_q.size() == 2) exp_ill = 1'b1;
   endtask
   initial begin
      tab[0]  = '{OP_LW,    6'h00,      1'b0, 5, 20'h01234};
      tab[1]  = '{OP_SW,    6'h00,      1'b0, 4, 20'h01250};
      tab[2]  = '{OP_RTYPE, 6'b100000,  1'b0, 4, 20'h01670};
      tab[3]  = '{OP_RTYPE, 6'b100010,  1'b1, 4, 20'h01670};
      tab[4]  = '{OP_RTYPE, 6'b100100,  1'b0, 4, 20'h01670};
      tab[5]  = '{OP_RTYPE, 6'b100101,  1'b0, 4, 20'h01670};
      tab[6]  = '{OP_RTYPE, 6'b101010,  1'b0, 4, 20'h01670};
      tab[7]  = '{OP_RTYPE, 6'b100111,  1'b0, 4, 20'h01670};
      tab[8]  = '{OP_BEQ,   6'h03,      1'b1, 3, 20'h01800};
      tab[9]  = '{OP_BEQ,   6'h03,      1'b0, 3, 20'h01800};
      tab[10] = '{OP_ADDI,  6'h04,      1'b0, 4, 20'h019A0};
      tab[11] = '{OP_SLTI,  6'h04,      1'b1, 4, 20'h019A0};
      tab[12] = '{OP_SW,    6'b101010,  1'b1, 4, 20'h01250};
      tab[13] = '{OP_LW,    6'b100010,  1'b1, 5, 20'h01234};
      tab[14] = '{6'b111111, 6'h00,     1'b0, 2, 20'h01000};
      tab[15] = '{OP_RTYPE, 6'b000001,  1'b0, 2, 20'h01000};
      reset = 1'b1;
      exp_ill = 1'b0;
      bus.Op = 6'h00;
      bus.Function = 6'h00;
      bus.Zero = 1'b0;
      repeat (2) @(negedge clk);
      step_check(0, "reset");
      reset = 1'b0;
      foreach (tab[k]) begin
         exp_q.delete();
         for (int i = 0; i < tab[k].len; i++) exp_q.push_back(int'(tab[k].seq[19 - 4*i -: 4]));
         run(tab[k].op, tab[k].fn, tab[k].z, $sformatf("table%0d", k));
      end
      build_seq(OP_RTYPE, 6'b100000);
      run(OP_RTYPE, 6'b100000, 1'b0, "sticky");
      bus.Op = OP_LW;
      step_check(0, "mid_fetch");
      step_check(1, "mid_decode");
      step_check(2, "mid_memadr");
      reset = 1'b1;
      step_check(3, "rst_memrd");
      reset = 1'b0;
      build_seq(OP_LW, 6'h00);
      run(OP_LW, 6'h00, 1'b0, "after_rst");
      for (int n = 0; n < 300; n++) begin
         logic [5:0] op, fn;
         int sel;
         sel = int'($urandom_range(0, 8));
         fn = 6'($urandom);
         case (sel)
            0: op = OP_LW;
            1: op = OP_SW;
            2: begin op = OP_RTYPE; fn = legal_fn[$urandom_range(0, 5)]; end
            3: op = OP_BEQ;
            4: op = OP_ADDI;
            5: op = OP_SLTI;
            6: op = OP_RTYPE;
            default: op = 6'($urandom);
         endcase
         build_seq(op, fn);
         run(op, fn, 1'($urandom), "random");
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            step_check(0, "rand_rst");
            reset = 1'b0;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
